mul_result_stage: RTL and testbench

- Multiplier result stage. Sits directly downstream of the two-stage multiplier, which delivers the double-width product in the Memory stage.
- Selects the architecturally requested XLEN-bit result: low half, high half, or the sign-extended 32-bit W-op result.
- Buffers the result in a 2-entry skid FIFO with valid/ready handshakes on both sides. This decouples multiplier issue from writeback-port arbitration.

---
 rtl/mul_result_stage_if.sv | 39 +++
 rtl/mul_result_stage.sv | 130 +++++++++++++
 tb/tb_mul_result_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mul_result_stage_if.sv
// Handshake/data bundle between the multiplier (M side), the result stage and
// writeback (W side). The optional OvfW flag exists only when
// MUL_RESULT_OVF_FLAG_EN is defined.
interface mul_result_stage_if #(
  parameter int XLEN = 64
);
  logic [2*XLEN-1:0] ProdM;
  logic [2:0]        Funct3M;
  logic              W64M;
  logic              ValidM;
  logic              ReadyM;
  logic              FlushW;
  logic              ValidW;
  logic              ReadyW;
  logic [XLEN-1:0]   MDUResultW;
`ifdef MUL_RESULT_OVF_FLAG_EN
  logic              OvfW;
`endif

`ifdef MUL_RESULT_OVF_FLAG_EN
  modport master (
    output ProdM, Funct3M, W64M, ValidM, FlushW, ReadyW,
    input  ReadyM, ValidW, MDUResultW, OvfW
  );
  modport slave (
    input  ProdM, Funct3M, W64M, ValidM, FlushW, ReadyW,
    output ReadyM, ValidW, MDUResultW, OvfW
  );
`else
  modport master (
    output ProdM, Funct3M, W64M, ValidM, FlushW, ReadyW,
    input  ReadyM, ValidW, MDUResultW
  );
  modport slave (
    input  ProdM, Funct3M, W64M, ValidM, FlushW, ReadyW,
    output ReadyM, ValidW, MDUResultW
  );
`endif
endinterface

// File: rtl/mul_result_stage.sv
// Multiplier result stage: picks the XLEN-bit result (low half, high half or
// sign-extended 32-bit W-op) from the double-width product and buffers it in
// a 2-entry FIFO with valid/ready on both sides.
// Optional feature macro: MUL_RESULT_OVF_FLAG_EN adds a per-entry OvfW
// signed-overflow hint.
// XLEN must match the XLEN of the connected interface instance.
module mul_result_stage #(
  parameter int XLEN = 64
) (
  input logic               clk,
  input logic               reset,
  mul_result_stage_if.slave bus
);

  logic [XLEN-1:0] w_sext;
  logic            w_wop;
  logic            w_is_high;
  logic [XLEN-1:0] w_sel;
  logic            w_push;
  logic            w_pop;
  logic            w_ready_m;
  logic            w_valid_w;

  logic [1:0]      r_count;
  logic            r_wrptr;
  logic            r_rdptr;
  logic [XLEN-1:0] r_entry [2];

`ifdef MUL_RESULT_OVF_FLAG_EN
  logic            w_wovf;
  logic            w_ovf;
  logic            r_ovf [2];

  // True when the upper part is not a pure sign extension of the lower part.
  function automatic logic sext_mismatch(input logic [XLEN-1:0] upper,
                                         input logic            sign);
    return upper != {XLEN{sign}};
  endfunction
`endif

  // W-form ops only exist on RV64; on RV32 W64M has no effect.
  generate
    if (XLEN == 64) begin : g_wop
      assign w_sext = {{32{bus.ProdM[31]}}, bus.ProdM[31:0]};
      assign w_wop  = bus.W64M;
`ifdef MUL_RESULT_OVF_FLAG_EN
      assign w_wovf = (bus.ProdM[63:32] != {32{bus.ProdM[31]}});
`endif
    end else begin : g_no_wop
      assign w_sext = bus.ProdM[XLEN-1:0];
      assign w_wop  = 1'b0;
`ifdef MUL_RESULT_OVF_FLAG_EN
      assign w_wovf = 1'b0;
`endif
    end
  endgenerate

  // Select the architectural result before storage; 1xx encodings act as MUL.
  always_comb begin
    w_is_high = ~bus.Funct3M[2] & (bus.Funct3M[1:0] != 2'b00);
    w_sel     = bus.ProdM[XLEN-1:0];
`ifdef MUL_RESULT_OVF_FLAG_EN
    w_ovf     = sext_mismatch(bus.ProdM[2*XLEN-1:XLEN], bus.ProdM[XLEN-1]);
`endif
    if (w_is_high) begin
      w_sel = bus.ProdM[2*XLEN-1:XLEN];
`ifdef MUL_RESULT_OVF_FLAG_EN
      w_ovf = 1'b0;
`endif
    end else if (w_wop) begin
      w_sel = w_sext;
`ifdef MUL_RESULT_OVF_FLAG_EN
      w_ovf = w_wovf;
`endif
    end
  end

  // ReadyM decodes only the registered count, so there is no path from ReadyW.
  assign w_ready_m = (r_count != 2'd2);
  assign w_valid_w = (r_count != 2'd0);
  assign w_push    = bus.ValidM & w_ready_m;
  assign w_pop     = w_valid_w & bus.ReadyW;

  // FIFO control: flush outranks push/pop and drops any incoming entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 2'd0;
      r_wrptr <= 1'b0;
      r_rdptr <= 1'b0;
    end else if (bus.FlushW) begin
      r_count <= 2'd0;
      r_wrptr <= 1'b0;
      r_rdptr <= 1'b0;
    end else begin
      if (w_push) r_wrptr <= ~r_wrptr;
      if (w_pop)  r_rdptr <= ~r_rdptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: written on an accepted, non-flushed push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_entry[0] <= '0;
      r_entry[1] <= '0;
`ifdef MUL_RESULT_OVF_FLAG_EN
      r_ovf[0]   <= 1'b0;
      r_ovf[1]   <= 1'b0;
`endif
    end else if (w_push && !bus.FlushW) begin
      r_entry[r_wrptr] <= w_sel;
`ifdef MUL_RESULT_OVF_FLAG_EN
      r_ovf[r_wrptr]   <= w_ovf;
`endif
    end
  end

  assign bus.ReadyM     = w_ready_m;
  assign bus.ValidW     = w_valid_w;
  // Head is masked to zero when empty so stale storage never leaks out.
  assign bus.MDUResultW = w_valid_w ? r_entry[r_rdptr] : '0;
`ifdef MUL_RESULT_OVF_FLAG_EN
  assign bus.OvfW       = w_valid_w ? r_ovf[r_rdptr] : 1'b0;
`endif

endmodule

// File: tb/tb_mul_result_stage.sv
// Directed bench for mul_result_stage (XLEN=64). OvfW checks are compiled in
// only when MUL_RESULT_OVF_FLAG_EN is defined.
module tb_mul_result_stage;
  localparam int XLEN = 64;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mul_result_stage_if #(.XLEN(XLEN)) bus ();

  mul_result_stage #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_val(input logic [2*XLEN-1:0] prod, input logic [2:0] f3,
                          input logic w64);
    bus.ProdM   = prod;
    bus.Funct3M = f3;
    bus.W64M    = w64;
    bus.ValidM  = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    checks++; if (bus.ValidW !== 1'b0) begin failures++; $display("FAIL reset_validw got=%0b exp=0", bus.ValidW); end
    checks++; if (bus.MDUResultW !== 64'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.MDUResultW); end
    checks++; if (bus.ReadyM !== 1'b1) begin failures++; $display("FAIL reset_readym got=%0b exp=1", bus.ReadyM); end
  endtask

  task automatic test_low_half();
    bus.ReadyW = 1'b1;
    push_val(128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, 3'b000, 1'b0);
    #1;
    checks++; if (bus.ValidW !== 1'b0) begin failures++; $display("FAIL low_no_bypass got=%0b exp=0", bus.ValidW); end
    step();
    bus.ValidM = 1'b0;
    checks++; if (bus.ValidW !== 1'b1) begin failures++; $display("FAIL low_validw got=%0b exp=1", bus.ValidW); end
    checks++; if (bus.MDUResultW !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL low_result got=%h exp=fffffffffffffffe", bus.MDUResultW); end
`ifdef MUL_RESULT_OVF_FLAG_EN
    checks++; if (bus.OvfW !== 1'b1) begin failures++; $display("FAIL low_ovf got=%0b exp=1", bus.OvfW); end
`endif
    step();
    checks++; if (bus.ValidW !== 1'b0) begin failures++; $display("FAIL low_drain got=%0b exp=0", bus.ValidW); end
  endtask

  task automatic test_high_half();
    logic [2:0]      f3s  [4];
    logic [XLEN-1:0] exps [4];
    f3s[0] = 3'b011; exps[0] = 64'h0000_0000_0000_0001;
    f3s[1] = 3'b001; exps[1] = 64'h0000_0000_0000_0001;
    f3s[2] = 3'b010; exps[2] = 64'h0000_0000_0000_0001;
    f3s[3] = 3'b100; exps[3] = 64'hFFFF_FFFF_FFFF_FFFE;
    bus.ReadyW = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_val(128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, f3s[i], 1'b0);
      step();
      bus.ValidM = 1'b0;
      checks++; if (bus.MDUResultW !== exps[i]) begin failures++; $display("FAIL sel_f3_%0d got=%h exp=%h", i, bus.MDUResultW, exps[i]); end
`ifdef MUL_RESULT_OVF_FLAG_EN
      checks++; if (bus.OvfW !== (i == 3)) begin failures++; $display("FAIL sel_ovf_%0d got=%0b exp=%0b", i, bus.OvfW, (i == 3)); end
`endif
      step();
    end
  endtask

  task automatic test_wop();
    bus.ReadyW = 1'b1;
    push_val(128'h0000_0000_0000_0000_0000_0001_8000_0000, 3'b000, 1'b1);
    step();
    bus.ValidM = 1'b0;
    checks++; if (bus.MDUResultW !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL wop_result got=%h exp=ffffffff80000000", bus.MDUResultW); end
`ifdef MUL_RESULT_OVF_FLAG_EN
    checks++; if (bus.OvfW !== 1'b1) begin failures++; $display("FAIL wop_ovf got=%0b exp=1", bus.OvfW); end
`endif
    step();
    push_val(128'h0000_0000_0000_0000_0000_0001_8000_0000, 3'b001, 1'b1);
    step();
    bus.ValidM = 1'b0;
    checks++; if (bus.MDUResultW !== 64'h0) begin failures++; $display("FAIL wop_high_ignored got=%h exp=0", bus.MDUResultW); end
    step();
  endtask

  task automatic test_fill_stall();
    bus.ReadyW = 1'b0;
    push_val(128'd5, 3'b000, 1'b0);
    step();
    push_val(128'd7, 3'b000, 1'b0);
    step();
    checks++; if (bus.ReadyM !== 1'b0) begin failures++; $display("FAIL full_readym got=%0b exp=0", bus.ReadyM); end
    checks++; if (bus.MDUResultW !== 64'd5) begin failures++; $display("FAIL full_head got=%0d exp=5", bus.MDUResultW); end
    push_val(128'd9, 3'b000, 1'b0);
    step();
    bus.ValidM = 1'b0;
    checks++; if (bus.MDUResultW !== 64'd5 || bus.ReadyM !== 1'b0) begin failures++; $display("FAIL full_ignore got=%0d/%0b exp=5/0", bus.MDUResultW, bus.ReadyM); end
    bus.ReadyW = 1'b1;
    step();
    checks++; if (bus.MDUResultW !== 64'd7) begin failures++; $display("FAIL drain_second got=%0d exp=7", bus.MDUResultW); end
    checks++; if (bus.ReadyM !== 1'b1) begin failures++; $display("FAIL drain_readym got=%0b exp=1", bus.ReadyM); end
    step();
    checks++; if (bus.ValidW !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", bus.ValidW); end
  endtask

  task automatic test_back_to_back();
    bus.ReadyW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_val(128'd11 + 128'(i), 3'b000, 1'b0);
      step();
      checks++; if (bus.ValidW !== 1'b1 || bus.MDUResultW !== 64'(11 + i)) begin failures++; $display("FAIL b2b_%0d got=%0b/%0d exp=1/%0d", i, bus.ValidW, bus.MDUResultW, 11 + i); end
    end
    bus.ValidM = 1'b0;
    step();
    checks++; if (bus.ValidW !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0b exp=0", bus.ValidW); end
  endtask

  task automatic test_flush();
    bus.ReadyW = 1'b0;
    push_val(128'h21, 3'b000, 1'b0);
    step();
    checks++; if (bus.ValidW !== 1'b1) begin failures++; $display("FAIL flush_pre got=%0b exp=1", bus.ValidW); end
    bus.FlushW = 1'b1;
    push_val(128'h22, 3'b000, 1'b0);
    step();
    bus.FlushW = 1'b0;
    bus.ValidM = 1'b0;
    checks++; if (bus.ValidW !== 1'b0 || bus.MDUResultW !== 64'h0 || bus.ReadyM !== 1'b1) begin failures++; $display("FAIL flush_post got=%0b/%h/%0b exp=0/0/1", bus.ValidW, bus.MDUResultW, bus.ReadyM); end
    step();
    checks++; if (bus.ValidW !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%0b exp=0", bus.ValidW); end
  endtask

  task automatic test_reset_mid();
    bus.ReadyW = 1'b0;
    push_val(128'h31, 3'b000, 1'b0);
    step();
    push_val(128'h32, 3'b000, 1'b0);
    step();
    bus.ValidM = 1'b0;
    checks++; if (bus.ReadyM !== 1'b0) begin failures++; $display("FAIL rmid_full got=%0b exp=0", bus.ReadyM); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.ValidW !== 1'b0 || bus.MDUResultW !== 64'h0) begin failures++; $display("FAIL rmid_async got=%0b/%h exp=0/0", bus.ValidW, bus.MDUResultW); end
    step();
    reset = 1'b1;
    step();
    checks++; if (bus.ValidW !== 1'b0 || bus.ReadyM !== 1'b1) begin failures++; $display("FAIL rmid_release got=%0b/%0b exp=0/1", bus.ValidW, bus.ReadyM); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    bus.ProdM   = '0;
    bus.Funct3M = 3'b000;
    bus.W64M    = 1'b0;
    bus.ValidM  = 1'b0;
    bus.FlushW  = 1'b0;
    bus.ReadyW  = 1'b0;
    test_reset();
    test_low_half();
    test_high_half();
    test_wop();
    test_fill_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
